// File: rtl/pending_priority_encoder.sv
// ============================================================================
// Module      : pending_priority_encoder
// Description : Sticky pending-request register with a priority-encoded index
//               and a valid/ready consume handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pending_priority_encoder #(
  parameter int N         = 4,
  parameter int W         = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i,
  input  logic         clr,
  input  logic         ready,
  output logic [W-1:0] o,
  output logic         valid,
  output logic [N-1:0] pend,
  output logic         multi,
  output logic         ovf
);

  localparam logic [N-1:0] c_one = N'(1);

  logic [N-1:0] r_pend;
  logic         r_ovf;
  logic [W-1:0] w_idx;
  logic [N-1:0] w_served;
  logic [N-1:0] w_pend_next;
  logic         w_ovf_set;

  // The last matching bit visited by the loop wins, so the scan direction
  // sets the priority order.
  generate
    if (MSB_FIRST) begin : g_msb_first
      always_comb begin
        w_idx = '0;
        for (int k = 0; k < N; k++) begin
          if (r_pend[k]) w_idx = W'(k);
        end
      end
    end else begin : g_lsb_first
      always_comb begin
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
          if (r_pend[k]) w_idx = W'(k);
        end
      end
    end
  endgenerate

  assign valid       = |r_pend;
  assign o           = w_idx;
  assign pend        = r_pend;
  assign ovf         = r_ovf;
  assign multi       = |(r_pend & (r_pend - c_one));

  assign w_served    = (valid && ready) ? (c_one << w_idx) : '0;
  // A new request on the bit being served keeps it pending without overflow.
  assign w_pend_next = (r_pend & ~w_served) | i;
  assign w_ovf_set   = |(i & r_pend & ~w_served);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else if (clr) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      r_ovf  <= r_ovf | w_ovf_set;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pending_priority_encoder.sv
// ============================================================================
// Module      : tb_pending_priority_encoder
// Description : Directed, table-driven bench for pending_priority_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pending_priority_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // N=4, lowest index wins
  logic [3:0] i4 = '0;
  logic       clr4 = 1'b0, rdy4 = 1'b0;
  logic [1:0] o4;
  logic       v4, m4, ovf4;
  logic [3:0] p4;

  // N=4, highest index wins
  logic [3:0] im = '0;
  logic       rdym = 1'b0;
  logic [1:0] om;
  logic       vm, mm, ovfm;
  logic [3:0] pm;

  // N=8, W=3, lowest index wins
  logic [7:0] i8 = '0;
  logic       rdy8 = 1'b0;
  logic [2:0] o8;
  logic       v8, m8, ovf8;
  logic [7:0] p8;

  // N=5, W=3, highest index wins
  logic [4:0] i5 = '0;
  logic       rdy5 = 1'b0;
  logic [2:0] o5;
  logic       v5, m5, ovf5;
  logic [4:0] p5;

  pending_priority_encoder #(.N(4), .W(2), .MSB_FIRST(1'b0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .i(i4), .clr(clr4), .ready(rdy4),
    .o(o4), .valid(v4), .pend(p4), .multi(m4), .ovf(ovf4));

  pending_priority_encoder #(.N(4), .W(2), .MSB_FIRST(1'b1)) u_dm (
    .clk(clk), .rst_n(rst_n), .i(im), .clr(1'b0), .ready(rdym),
    .o(om), .valid(vm), .pend(pm), .multi(mm), .ovf(ovfm));

  pending_priority_encoder #(.N(8), .W(3), .MSB_FIRST(1'b0)) u_d8 (
    .clk(clk), .rst_n(rst_n), .i(i8), .clr(1'b0), .ready(rdy8),
    .o(o8), .valid(v8), .pend(p8), .multi(m8), .ovf(ovf8));

  pending_priority_encoder #(.N(5), .W(3), .MSB_FIRST(1'b1)) u_d5 (
    .clk(clk), .rst_n(rst_n), .i(i5), .clr(1'b0), .ready(rdy5),
    .o(o5), .valid(v5), .pend(p5), .multi(m5), .ovf(ovf5));

  typedef struct {
    logic [3:0] i;
    logic       clr;
    logic       ready;
    logic [1:0] o;
    logic       valid;
    logic [3:0] pend;
    logic       multi;
    logic       ovf;
  } vec_t;

  localparam int c_nvec = 18;
  vec_t vec [c_nvec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, samples 1 time unit after the edge, then idles inputs.
  task automatic step4(input logic [3:0] ii, input logic c, input logic r);
    i4 = ii; clr4 = c; rdy4 = r;
    @(posedge clk); #1;
    i4 = '0; clr4 = 1'b0; rdy4 = 1'b0;
  endtask

  task automatic stepm(input logic [3:0] ii, input logic r);
    im = ii; rdym = r;
    @(posedge clk); #1;
    im = '0; rdym = 1'b0;
  endtask

  task automatic step8(input logic [7:0] ii, input logic r);
    i8 = ii; rdy8 = r;
    @(posedge clk); #1;
    i8 = '0; rdy8 = 1'b0;
  endtask

  task automatic step5(input logic [4:0] ii, input logic r);
    i5 = ii; rdy5 = r;
    @(posedge clk); #1;
    i5 = '0; rdy5 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          i      clr   ready  o     valid pend   multi ovf   (outputs after the edge)
    vec[0]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b0, 1'b0};
    vec[1]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vec[2]  = '{4'b1010, 1'b0, 1'b1, 2'd1, 1'b1, 4'b1010, 1'b1, 1'b0};
    vec[3]  = '{4'b0000, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b0, 1'b0};
    vec[4]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vec[5]  = '{4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0};
    vec[6]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0};
    vec[7]  = '{4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b1};
    vec[8]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1};
    vec[9]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vec[10] = '{4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0};
    vec[11] = '{4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0};
    vec[12] = '{4'b0011, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vec[13] = '{4'b1000, 1'b0, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b0, 1'b0};
    vec[14] = '{4'b0000, 1'b0, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b0, 1'b0};
    vec[15] = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, 4'b1001, 1'b1, 1'b0};
    vec[16] = '{4'b0000, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b0, 1'b0};
    vec[17] = '{4'b0110, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0110, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_d4", {30'd0, o4, v4, p4, m4, ovf4}, 32'd0);
    chk("reset_d8", {o8, v8, p8, m8, ovf8}, 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < c_nvec; k++) begin
      step4(vec[k].i, vec[k].clr, vec[k].ready);
      chk($sformatf("vec%0d {o,valid,pend,multi,ovf}", k),
          {23'd0, o4, v4, p4, m4, ovf4},
          {23'd0, vec[k].o, vec[k].valid, vec[k].pend, vec[k].multi, vec[k].ovf});
    end

    // Highest-first service order on the same request pattern
    stepm(4'b1010, 1'b1);
    chk("msb_first_1st {o,valid,multi}", {om, vm, mm}, {2'd3, 1'b1, 1'b1});
    stepm(4'b0000, 1'b1);
    chk("msb_first_2nd {o,valid,multi}", {om, vm, mm}, {2'd1, 1'b1, 1'b0});
    stepm(4'b0000, 1'b1);
    chk("msb_first_done {o,valid,pend}", {om, vm, pm}, {2'd0, 1'b0, 4'b0000});

    // Non-power-of-two width
    step5(5'b10001, 1'b0);
    chk("n5_first {o,valid,multi}", {o5, v5, m5}, {3'd4, 1'b1, 1'b1});
    step5(5'b00000, 1'b1);
    chk("n5_second {o,valid,pend}", {o5, v5, p5}, {3'd0, 1'b1, 5'b00001});
    step5(5'b00000, 1'b1);
    chk("n5_done valid", {31'd0, v5}, 32'd0);

    // One-hot sweep on the 8-wide instance
    for (int k = 0; k < 8; k++) begin
      step8(8'(1 << k), 1'b0);
      chk($sformatf("onehot%0d {o,valid,pend}", k), {o8, v8, p8}, {3'(k), 1'b1, 8'(1 << k)});
      step8(8'h00, 1'b1);
      chk($sformatf("onehot%0d_served valid", k), {31'd0, v8}, 32'd0);
    end

    // Full burst served one index per cycle
    step8(8'hFF, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("burst%0d {o,valid}", k), {o8, v8}, {3'(k), 1'b1});
      step8(8'h00, 1'b1);
    end
    chk("burst_done {valid,pend}", {v8, p8}, {1'b0, 8'h00});

    // Asynchronous reset landing between edges with a full, overflowed register
    step4(4'b1111, 1'b0, 1'b0);
    step4(4'b1111, 1'b0, 1'b0);
    chk("pre_reset {pend,multi,ovf}", {p4, m4, ovf4}, {4'b1111, 1'b1, 1'b1});
    step4(4'b0000, 1'b0, 1'b1);
    step4(4'b0000, 1'b0, 1'b0);
    step4(4'b0000, 1'b0, 1'b1);
    chk("pre_reset_served {o,pend}", {o4, p4}, {2'd2, 4'b1100});
    rdy4 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset {o,valid,pend,multi,ovf}", {o4, v4, p4, m4, ovf4}, 9'd0);
    #3;
    rst_n = 1'b1;
    rdy4 = 1'b0;
    step4(4'b0000, 1'b0, 1'b0);
    chk("post_reset {valid,pend}", {v4, p4}, {1'b0, 4'b0000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
